// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset CPU: opcodes, FSM state
// encodings, ALU/PC/register-destination select codes and the control word.
package mc_cpu_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_BRANCH,
    CLS_OTHER
  } op_class_e;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       db_data_src;
    logic       n_rd;
    logic       n_wr;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       ext_sel;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  // Quiet word: nothing written, memory strobes inactive, every select at 0.
  localparam ctrl_t CTRL_IDLE = '{
    pc_wre: 1'b0, ir_wre: 1'b0, reg_wre: 1'b0, alu_src_a: 1'b0,
    alu_src_b: 1'b0, db_data_src: 1'b0, n_rd: 1'b1, n_wr: 1'b1,
    reg_dst: 2'b00, wr_reg_d_src: 1'b0, ext_sel: 1'b0,
    pc_src: 2'b00, alu_op: 3'b000
  };

  function automatic op_class_e op_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND,
      OP_ANDI, OP_ORI, OP_SLL, OP_SLTI: return CLS_ALU;
      OP_SW, OP_LW:                     return CLS_MEM;
      OP_BEQ, OP_BNE, OP_BLTZ:          return CLS_BRANCH;
      default:                          return CLS_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from FSM state, opcode and ALU flags.
// Only sEXE_BR looks at zero/sign; everything else is Moore on state + opcode.
module mc_ctrl_decode
  import mc_cpu_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       rst_i,
  input  state_e     state_i,
  input  logic       halt_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       sign_i,
  output ctrl_t      ctrl_o
);

  logic branch_taken;

  always_comb begin
    branch_taken = 1'b0;
    case (opcode_i)
      OP_BEQ:  branch_taken = zero_i;
      OP_BNE:  branch_taken = ~zero_i;
      OP_BLTZ: branch_taken = sign_i;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every field gets its default before any branch so no path can leave
    // a bit unassigned and infer a latch.
    ctrl_o = CTRL_IDLE;

    // Reset overrides everything, so the datapath sees a quiet word mid-instruction.
    if (!rst_i) begin
      ctrl_o.alu_src_a    = (opcode_i == OP_SLL);
      ctrl_o.alu_src_b    = (opcode_i inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW});
      ctrl_o.ext_sel      = !(opcode_i inside {OP_ANDI, OP_ORI});
      ctrl_o.wr_reg_d_src = (opcode_i != OP_JAL);

      case (opcode_i)
        OP_ADD, OP_SUB, OP_AND, OP_SLL:                 ctrl_o.reg_dst = REGDST_RD;
        OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW:      ctrl_o.reg_dst = REGDST_RT;
        default:                                        ctrl_o.reg_dst = REGDST_RA;
      endcase

      case (opcode_i)
        OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ctrl_o.alu_op = ALU_SUB;
        OP_SLL:                          ctrl_o.alu_op = ALU_SLL;
        OP_ORI:                          ctrl_o.alu_op = ALU_OR;
        OP_AND, OP_ANDI:                 ctrl_o.alu_op = ALU_AND;
        OP_SLTI:                         ctrl_o.alu_op = ALU_SLT;
        default:                         ctrl_o.alu_op = ALU_ADD;
      endcase

      if (!halt_i) begin
        case (state_i)
          S_IF: ctrl_o.ir_wre = 1'b1;
          S_ID: begin
            // Jumps and NOPs retire here; a halt opcode retires nothing.
            if (opcode_i != HALT_OP && op_class(opcode_i) == CLS_OTHER) begin
              ctrl_o.pc_wre = 1'b1;
              if (opcode_i == OP_J || opcode_i == OP_JAL) ctrl_o.pc_src = PCSRC_JUMP;
              else if (opcode_i == OP_JR)                 ctrl_o.pc_src = PCSRC_RS;
              ctrl_o.reg_wre = (opcode_i == OP_JAL);
            end
          end
          S_EXE_BR: begin
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = branch_taken ? PCSRC_BRANCH : PCSRC_SEQ;
          end
          S_MEM: begin
            if (opcode_i == OP_LW) begin
              ctrl_o.n_rd        = 1'b0;
              ctrl_o.db_data_src = 1'b1;
            end else if (opcode_i == OP_SW) begin
              ctrl_o.n_wr   = 1'b0;
              ctrl_o.pc_wre = 1'b1;
            end
          end
          S_WB_LD: begin
            ctrl_o.reg_wre     = 1'b1;
            ctrl_o.pc_wre      = 1'b1;
            ctrl_o.db_data_src = 1'b1;
          end
          S_WB_AL: begin
            ctrl_o.reg_wre = 1'b1;
            ctrl_o.pc_wre  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB state register and next-state
// logic, with a sticky halt flag that parks the machine in sID until Reset.
module mc_control_fsm
  import mc_cpu_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       nRD,
  output logic       nWR,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       ExtSel,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  state_e state_q, state_d;
  logic   halt_q, halt_d;
  ctrl_t  ctrl;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of block ordering.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IF;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (halt_q) begin
          state_d = S_ID;
        end else if (Opcode == HALT_OP) begin
          state_d = S_ID;
          halt_d  = 1'b1;
        end else begin
          case (op_class(Opcode))
            CLS_ALU:    state_d = S_EXE_AL;
            CLS_MEM:    state_d = S_EXE_LS;
            CLS_BRANCH: state_d = S_EXE_BR;
            default:    state_d = S_IF;
          endcase
        end
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (Opcode == OP_LW) ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  mc_ctrl_decode #(
    .HALT_OP (HALT_OP)
  ) u_decode (
    .rst_i    (Reset),
    .state_i  (state_q),
    .halt_i   (halt_q),
    .opcode_i (Opcode),
    .zero_i   (zero),
    .sign_i   (sign),
    .ctrl_o   (ctrl)
  );

  assign PCWre     = ctrl.pc_wre;
  assign IRWre     = ctrl.ir_wre;
  assign RegWre    = ctrl.reg_wre;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign DBDataSrc = ctrl.db_data_src;
  assign nRD       = ctrl.n_rd;
  assign nWR       = ctrl.n_wr;
  assign RegDst    = ctrl.reg_dst;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign ExtSel    = ctrl.ext_sel;
  assign PCSrc     = ctrl.pc_src;
  assign ALUOp     = ctrl.alu_op;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through its
// states and compares control lines against hand-derived values.
module tb_mc_control_fsm;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       zero, sign;
  logic       PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, nRD, nWR;
  logic [1:0] RegDst, PCSrc;
  logic       WrRegDSrc, ExtSel;
  logic [2:0] ALUOp, state;

  int checks   = 0;
  int failures = 0;

  mc_control_fsm dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Opcode    (Opcode),
    .zero      (zero),
    .sign      (sign),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .DBDataSrc (DBDataSrc),
    .nRD       (nRD),
    .nWR       (nWR),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .ExtSel    (ExtSel),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp),
    .state     (state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset  = 1'b1;
    Opcode = 6'b000000;
    zero   = 1'b0;
    sign   = 1'b0;
    #2;
    check("rst_state", 8'(state), 8'h0);
    check("rst_irwre", 8'(IRWre), 8'h0);
    check("rst_nrd", 8'(nRD), 8'h1);
    check("rst_nwr", 8'(nWR), 8'h1);
    check("rst_wrregdsrc", 8'(WrRegDSrc), 8'h0);
    check("rst_extsel", 8'(ExtSel), 8'h0);
    tick();
    Reset = 1'b0;
    #1;
    check("post_rst_irwre", 8'(IRWre), 8'h1);

    // ADD: 000 -> 001 -> 110 -> 111
    check("add_if_state", 8'(state), 8'h0);
    check("add_if_pcwre", 8'(PCWre), 8'h0);
    tick();
    check("add_id_state", 8'(state), 8'h1);
    check("add_id_pcwre", 8'(PCWre), 8'h0);
    check("add_id_irwre", 8'(IRWre), 8'h0);
    tick();
    check("add_exe_state", 8'(state), 8'h6);
    check("add_exe_pcwre", 8'(PCWre), 8'h0);
    check("add_exe_regwre", 8'(RegWre), 8'h0);
    tick();
    check("add_wb_state", 8'(state), 8'h7);
    check("add_wb_pcwre", 8'(PCWre), 8'h1);
    check("add_wb_regwre", 8'(RegWre), 8'h1);
    check("add_wb_regdst", 8'(RegDst), 8'h2);
    check("add_wb_aluop", 8'(ALUOp), 8'h0);
    tick();
    check("add_done_state", 8'(state), 8'h0);
    check("add_done_pcwre", 8'(PCWre), 8'h0);

    // LW: 000 -> 001 -> 010 -> 011 -> 100, then reset in sWB_LD
    Opcode = 6'b110001;
    tick();
    check("lw_id_state", 8'(state), 8'h1);
    tick();
    check("lw_exe_state", 8'(state), 8'h2);
    check("lw_exe_alusrcb", 8'(ALUSrcB), 8'h1);
    check("lw_exe_aluop", 8'(ALUOp), 8'h0);
    tick();
    check("lw_mem_state", 8'(state), 8'h3);
    check("lw_mem_nrd", 8'(nRD), 8'h0);
    check("lw_mem_dbsrc", 8'(DBDataSrc), 8'h1);
    check("lw_mem_pcwre", 8'(PCWre), 8'h0);
    tick();
    check("lw_wb_state", 8'(state), 8'h4);
    check("lw_wb_regwre", 8'(RegWre), 8'h1);
    check("lw_wb_regdst", 8'(RegDst), 8'h1);
    check("lw_wb_dbsrc", 8'(DBDataSrc), 8'h1);
    check("lw_wb_pcwre", 8'(PCWre), 8'h1);
    Reset = 1'b1;
    #1;
    check("midrst_state", 8'(state), 8'h0);
    check("midrst_regwre", 8'(RegWre), 8'h0);
    check("midrst_nrd", 8'(nRD), 8'h1);
    #1;
    Reset = 1'b0;
    #1;
    check("midrst_rel_state", 8'(state), 8'h0);
    check("midrst_rel_irwre", 8'(IRWre), 8'h1);

    // SW: 000 -> 001 -> 010 -> 011 -> 000
    Opcode = 6'b110000;
    tick();
    tick();
    check("sw_exe_state", 8'(state), 8'h2);
    tick();
    check("sw_mem_state", 8'(state), 8'h3);
    check("sw_mem_nwr", 8'(nWR), 8'h0);
    check("sw_mem_nrd", 8'(nRD), 8'h1);
    check("sw_mem_pcwre", 8'(PCWre), 8'h1);
    tick();
    check("sw_done_state", 8'(state), 8'h0);

    // BEQ taken
    Opcode = 6'b110100;
    zero   = 1'b1;
    tick();
    tick();
    check("beq_t_state", 8'(state), 8'h5);
    check("beq_t_pcsrc", 8'(PCSrc), 8'h1);
    check("beq_t_pcwre", 8'(PCWre), 8'h1);
    check("beq_t_aluop", 8'(ALUOp), 8'h1);
    tick();
    check("beq_t_done", 8'(state), 8'h0);

    // BEQ not taken
    zero = 1'b0;
    tick();
    tick();
    check("beq_nt_pcsrc", 8'(PCSrc), 8'h0);
    check("beq_nt_pcwre", 8'(PCWre), 8'h1);
    tick();

    // BNE with zero = 0 is taken
    Opcode = 6'b110101;
    tick();
    tick();
    check("bne_t_pcsrc", 8'(PCSrc), 8'h1);
    tick();

    // BLTZ with sign = 1 is taken
    Opcode = 6'b110110;
    sign   = 1'b1;
    tick();
    tick();
    check("bltz_t_state", 8'(state), 8'h5);
    check("bltz_t_pcsrc", 8'(PCSrc), 8'h1);
    sign = 1'b0;
    #1;
    check("bltz_nt_pcsrc", 8'(PCSrc), 8'h0);
    tick();

    // JAL completes in ID
    Opcode = 6'b111010;
    tick();
    check("jal_id_state", 8'(state), 8'h1);
    check("jal_id_pcsrc", 8'(PCSrc), 8'h3);
    check("jal_id_regwre", 8'(RegWre), 8'h1);
    check("jal_id_regdst", 8'(RegDst), 8'h0);
    check("jal_id_wrsrc", 8'(WrRegDSrc), 8'h0);
    check("jal_id_pcwre", 8'(PCWre), 8'h1);
    tick();
    check("jal_done_state", 8'(state), 8'h0);

    // JR selects rs
    Opcode = 6'b111001;
    tick();
    check("jr_id_pcsrc", 8'(PCSrc), 8'h2);
    check("jr_id_regwre", 8'(RegWre), 8'h0);
    tick();

    // SLL and ORI select details, checked in sEXE_AL
    Opcode = 6'b011000;
    tick();
    tick();
    check("sll_alusrca", 8'(ALUSrcA), 8'h1);
    check("sll_aluop", 8'(ALUOp), 8'h2);
    tick();
    tick();
    Opcode = 6'b010010;
    tick();
    tick();
    check("ori_extsel", 8'(ExtSel), 8'h0);
    check("ori_aluop", 8'(ALUOp), 8'h3);
    check("ori_regdst", 8'(RegDst), 8'h1);
    tick();
    tick();

    // Unmapped opcode behaves as NOP
    Opcode = 6'b101010;
    tick();
    check("nop_id_state", 8'(state), 8'h1);
    check("nop_id_pcwre", 8'(PCWre), 8'h1);
    check("nop_id_pcsrc", 8'(PCSrc), 8'h0);
    tick();
    check("nop_done_state", 8'(state), 8'h0);

    // HALT: parked in sID with everything quiet, even if Opcode changes
    Opcode = 6'b111111;
    tick();
    check("halt_id_pcwre", 8'(PCWre), 8'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5) Opcode = 6'b000000;
      #1;
      check($sformatf("halt_state_%0d", i), 8'(state), 8'h1);
      check($sformatf("halt_en_%0d", i), {4'h0, PCWre, IRWre, RegWre, nWR}, 8'h1);
    end
    Reset = 1'b1;
    #1;
    check("halt_rst_state", 8'(state), 8'h0);
    #1;
    Reset = 1'b0;
    #1;
    check("halt_rel_irwre", 8'(IRWre), 8'h1);
    tick();
    check("halt_cleared_id", 8'(state), 8'h1);
    tick();
    check("halt_cleared_exe", 8'(state), 8'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
